common_split_buffer4: RTL and testbench

- In-pipeline 1-to-4 split buffer. It is the fan-out counterpart of the 4-to-1 cross buffer.
- Routes one valid/ready input stream to up to four output ports, selected by a per-beat destination mask. A mask with several bits set multicasts the beat.
- Each output port has a 2-entry registered FIFO. There is no combinational path from any next*_i_ready to prev_o_ready.
- Sits between an issuing stage and four parallel consumer pipes.

---
 rtl/common_split_buffer4.sv | 115 +++++++++++
 tb/tb_common_split_buffer4.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/common_split_buffer4.sv
// 1-to-4 split buffer: one valid/ready stream fanned out by destination mask into
// four independent 2-entry registered FIFOs; input ready never sees consumer ready.

module common_split_buffer4_fifo #(
  parameter int BUFFER_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [BUFFER_WIDTH-1:0] push_data,
  input  logic                    pop_ready,
  output logic [BUFFER_WIDTH-1:0] head_data,
  output logic                    head_valid,
  output logic                    space
);

  logic [BUFFER_WIDTH-1:0] mem_p0 [2];
  logic [1:0]              count;
  logic                    rptr;
  logic                    wptr;
  logic                    pop;

  assign pop        = head_valid & pop_ready;
  assign head_data  = mem_p0[rptr];
  assign head_valid = (count != 2'd0);
  assign space      = (count < 2'd2);

  // Storage stage: push never arrives at count 2 because space gates it upstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_p0[0] <= '0;
      mem_p0[1] <= '0;
      count     <= 2'd0;
      rptr      <= 1'b0;
      wptr      <= 1'b0;
    end else begin
      if (push) begin
        mem_p0[wptr] <= push_data;
        wptr         <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

module common_split_buffer4 #(
  parameter int BUFFER_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BUFFER_WIDTH-1:0] prev_i_data,
  input  logic [3:0]              prev_i_dst,
  input  logic                    prev_i_valid,
  output logic                    prev_o_ready,
  output logic [BUFFER_WIDTH-1:0] next0_o_data,
  output logic                    next0_o_valid,
  input  logic                    next0_i_ready,
  output logic [BUFFER_WIDTH-1:0] next1_o_data,
  output logic                    next1_o_valid,
  input  logic                    next1_i_ready,
  output logic [BUFFER_WIDTH-1:0] next2_o_data,
  output logic                    next2_o_valid,
  input  logic                    next2_i_ready,
  output logic [BUFFER_WIDTH-1:0] next3_o_data,
  output logic                    next3_o_valid,
  input  logic                    next3_i_ready
);

  logic [3:0]              space;
  logic [3:0]              push;
  logic [3:0]              port_ready;
  logic [3:0]              port_valid;
  logic [BUFFER_WIDTH-1:0] port_data [4];
  logic                    accept;

  // All-or-nothing multicast: ready only when every targeted port has room.
  assign prev_o_ready = &(~prev_i_dst | space);
  assign accept       = prev_i_valid & prev_o_ready;
  assign push         = {4{accept}} & prev_i_dst;

  assign port_ready = {next3_i_ready, next2_i_ready, next1_i_ready, next0_i_ready};

  for (genvar k = 0; k < 4; k++) begin : g_port
    common_split_buffer4_fifo #(
      .BUFFER_WIDTH(BUFFER_WIDTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[k]),
      .push_data (prev_i_data),
      .pop_ready (port_ready[k]),
      .head_data (port_data[k]),
      .head_valid(port_valid[k]),
      .space     (space[k])
    );
  end

  assign next0_o_data  = port_data[0];
  assign next1_o_data  = port_data[1];
  assign next2_o_data  = port_data[2];
  assign next3_o_data  = port_data[3];
  assign next0_o_valid = port_valid[0];
  assign next1_o_valid = port_valid[1];
  assign next2_o_valid = port_valid[2];
  assign next3_o_valid = port_valid[3];

endmodule

// File: tb/tb_common_split_buffer4.sv
// Directed bench for common_split_buffer4 with 8-bit payloads.

module tb_common_split_buffer4;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] prev_data;
  logic [3:0]   prev_dst;
  logic         prev_valid;
  logic         prev_ready;
  logic [3:0]   nrdy;
  logic [W-1:0] d0, d1, d2, d3;
  logic         v0, v1, v2, v3;
  logic [3:0]   n_valid;
  logic [31:0]  n_data;

  int vectors = 0;
  int errors  = 0;

  assign n_valid = {v3, v2, v1, v0};
  assign n_data  = {d3, d2, d1, d0};

  always #5 clk = ~clk;

  common_split_buffer4 #(.BUFFER_WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .prev_i_data  (prev_data),
    .prev_i_dst   (prev_dst),
    .prev_i_valid (prev_valid),
    .prev_o_ready (prev_ready),
    .next0_o_data (d0),
    .next0_o_valid(v0),
    .next0_i_ready(nrdy[0]),
    .next1_o_data (d1),
    .next1_o_valid(v1),
    .next1_i_ready(nrdy[1]),
    .next2_o_data (d2),
    .next2_o_valid(v2),
    .next2_i_ready(nrdy[2]),
    .next3_o_data (d3),
    .next3_o_valid(v3),
    .next3_i_ready(nrdy[3])
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic [3:0] m);
    prev_data  = d;
    prev_dst   = m;
    prev_valid = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    prev_dst = 4'b1111;
    #1;
    vectors++;
    if (n_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b want 0000", n_valid); end
    vectors++;
    if (n_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 00000000", n_data); end
    vectors++;
    if (prev_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", prev_ready); end
    tick;
    tick;
    reset = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    nrdy = 4'b1111;
    send(8'hA1, 4'b0001);
    vectors++;
    if (prev_ready !== 1'b1) begin errors++; $display("FAIL basic_ready0 got %b want 1", prev_ready); end
    tick;
    send(8'hB2, 4'b0100);
    vectors++;
    if (n_valid !== 4'b0001 || d0 !== 8'hA1) begin
      errors++; $display("FAIL basic_a1 got valid %b data %h want 0001 a1", n_valid, d0);
    end
    vectors++;
    if (prev_ready !== 1'b1) begin errors++; $display("FAIL basic_ready1 got %b want 1", prev_ready); end
    tick;
    prev_valid = 1'b0;
    vectors++;
    if (n_valid !== 4'b0100 || d2 !== 8'hB2) begin
      errors++; $display("FAIL basic_b2 got valid %b data %h want 0100 b2", n_valid, d2);
    end
    tick;
    vectors++;
    if (n_valid !== 4'b0000) begin errors++; $display("FAIL basic_idle got %b want 0000", n_valid); end
  endtask

  task automatic test_backpressure;
    nrdy = 4'b1101;
    send(8'h11, 4'b0010);
    tick;
    send(8'h22, 4'b0010);
    vectors++;
    if (prev_ready !== 1'b1) begin errors++; $display("FAIL bp_ready2 got %b want 1", prev_ready); end
    tick;
    send(8'h33, 4'b0010);
    vectors++;
    if (prev_ready !== 1'b0) begin errors++; $display("FAIL bp_full got %b want 0", prev_ready); end
    tick;
    vectors++;
    if (prev_ready !== 1'b0 || d1 !== 8'h11) begin
      errors++; $display("FAIL bp_hold got ready %b data %h want 0 11", prev_ready, d1);
    end
    nrdy = 4'b1111;
    tick;
    vectors++;
    if (v1 !== 1'b1 || d1 !== 8'h22 || prev_ready !== 1'b1) begin
      errors++; $display("FAIL bp_22 got valid %b data %h ready %b want 1 22 1", v1, d1, prev_ready);
    end
    tick;
    prev_valid = 1'b0;
    vectors++;
    if (v1 !== 1'b1 || d1 !== 8'h33) begin
      errors++; $display("FAIL bp_33 got valid %b data %h want 1 33", v1, d1);
    end
    tick;
    vectors++;
    if (v1 !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", v1); end
  endtask

  task automatic test_multicast;
    nrdy = 4'b0111;
    send(8'h31, 4'b1000);
    tick;
    send(8'h32, 4'b1000);
    tick;
    send(8'h5A, 4'b1111);
    vectors++;
    if (prev_ready !== 1'b0) begin errors++; $display("FAIL mc_blocked got %b want 0", prev_ready); end
    tick;
    vectors++;
    if (n_valid !== 4'b1000 || prev_ready !== 1'b0) begin
      errors++; $display("FAIL mc_none got valid %b ready %b want 1000 0", n_valid, prev_ready);
    end
    nrdy = 4'b1111;
    tick;
    vectors++;
    if (prev_ready !== 1'b1 || d3 !== 8'h32 || n_valid !== 4'b1000) begin
      errors++; $display("FAIL mc_room got ready %b d3 %h valid %b want 1 32 1000", prev_ready, d3, n_valid);
    end
    tick;
    prev_valid = 1'b0;
    vectors++;
    if (n_valid !== 4'b1111 || n_data !== 32'h5A5A5A5A) begin
      errors++; $display("FAIL mc_all got valid %b data %h want 1111 5a5a5a5a", n_valid, n_data);
    end
    tick;
    vectors++;
    if (n_valid !== 4'b0000) begin errors++; $display("FAIL mc_drain got %b want 0000", n_valid); end
  endtask

  task automatic test_drop;
    nrdy = 4'b0000;
    send(8'h01, 4'b1111);
    tick;
    send(8'h02, 4'b1111);
    tick;
    send(8'hFF, 4'b0000);
    vectors++;
    if (prev_ready !== 1'b1) begin errors++; $display("FAIL drop_ready got %b want 1", prev_ready); end
    tick;
    prev_valid = 1'b0;
    vectors++;
    if (n_valid !== 4'b1111 || n_data !== 32'h01010101) begin
      errors++; $display("FAIL drop_head got valid %b data %h want 1111 01010101", n_valid, n_data);
    end
    nrdy = 4'b1111;
    tick;
    vectors++;
    if (n_valid !== 4'b1111 || n_data !== 32'h02020202) begin
      errors++; $display("FAIL drop_second got valid %b data %h want 1111 02020202", n_valid, n_data);
    end
    tick;
    vectors++;
    if (n_valid !== 4'b0000) begin errors++; $display("FAIL drop_extra got %b want 0000", n_valid); end
  endtask

  task automatic test_back_to_back;
    int tx;
    int rx;
    logic acc;
    logic popd;
    nrdy = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      send(8'h40 + 8'(i), 4'b0001);
      vectors++;
      if (prev_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d got %b want 1", i, prev_ready); end
      tick;
      vectors++;
      if (v0 !== 1'b1 || d0 !== 8'h40 + 8'(i)) begin
        errors++; $display("FAIL stream_beat%0d got valid %b data %h want 1 %h", i, v0, d0, 8'h40 + 8'(i));
      end
    end
    prev_valid = 1'b0;
    tick;
    vectors++;
    if (v0 !== 1'b0) begin errors++; $display("FAIL stream_end got %b want 0", v0); end
    tx = 0;
    rx = 0;
    for (int c = 0; c < 100 && rx < 8; c++) begin
      nrdy[0]    = (c % 2 == 0);
      prev_valid = (tx < 8);
      prev_data  = 8'h80 + 8'(tx);
      prev_dst   = 4'b0001;
      #1;
      acc  = prev_valid & prev_ready;
      popd = v0 & nrdy[0];
      if (popd) begin
        vectors++;
        if (d0 !== 8'h80 + 8'(rx)) begin
          errors++; $display("FAIL toggle_beat%0d got %h want %h", rx, d0, 8'h80 + 8'(rx));
        end
        rx++;
      end
      if (acc) tx++;
      tick;
    end
    prev_valid = 1'b0;
    nrdy       = 4'b1111;
    vectors++;
    if (rx !== 8) begin errors++; $display("FAIL toggle_count got %0d want 8", rx); end
    tick;
    vectors++;
    if (v0 !== 1'b0) begin errors++; $display("FAIL toggle_dup got %b want 0", v0); end
  endtask

  task automatic test_reset_mid;
    nrdy = 4'b1010;
    send(8'h61, 4'b0101);
    tick;
    send(8'h62, 4'b0101);
    tick;
    send(8'h63, 4'b0101);
    vectors++;
    if (n_valid !== 4'b0101 || prev_ready !== 1'b0) begin
      errors++; $display("FAIL rst_full got valid %b ready %b want 0101 0", n_valid, prev_ready);
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (n_valid !== 4'b0000 || n_data !== 32'h0) begin
      errors++; $display("FAIL rst_async got valid %b data %h want 0000 00000000", n_valid, n_data);
    end
    vectors++;
    if (prev_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", prev_ready); end
    prev_valid = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    nrdy  = 4'b1111;
    tick;
    send(8'h77, 4'b0001);
    vectors++;
    if (prev_ready !== 1'b1 || n_valid !== 4'b0000) begin
      errors++; $display("FAIL rst_after got ready %b valid %b want 1 0000", prev_ready, n_valid);
    end
    tick;
    prev_valid = 1'b0;
    vectors++;
    if (n_valid !== 4'b0001 || d0 !== 8'h77) begin
      errors++; $display("FAIL rst_newbeat got valid %b data %h want 0001 77", n_valid, d0);
    end
    tick;
    vectors++;
    if (n_valid !== 4'b0000) begin errors++; $display("FAIL rst_stale got %b want 0000", n_valid); end
  endtask

  initial begin
    reset      = 1'b0;
    prev_data  = '0;
    prev_dst   = 4'b0000;
    prev_valid = 1'b0;
    nrdy       = 4'b1111;
    test_reset;
    test_basic;
    test_backpressure;
    test_multicast;
    test_drop;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
